truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper.sv | 116 +++++++++++
 tb/tb_truth_table_sweeper.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - drives 8 switch patterns, samples LEDs, checks against expected table
module truth_table_sweeper #(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] expected,
  input  logic        led0,
  input  logic        led1,
  input  logic        led2,
  input  logic        led3,
  output logic        sw0,
  output logic        sw1,
  output logic        sw2,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_count,
  output logic [2:0]  fail_idx,
  output logic [31:0] resp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t      state_q;
  logic [2:0]  idx_q;        // current pattern; also the registered switch value
  logic [7:0]  cnt_q;        // dwell counter, 0..DWELL-1
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [3:0]  fail_count_q;
  logic [2:0]  fail_idx_q;
  logic [31:0] resp_q;

  logic [3:0]  led_nib_d;
  logic [3:0]  exp_nib_d;
  logic        mismatch_d;
  logic        last_d;

  assign led_nib_d  = {led3, led2, led1, led0};
  assign exp_nib_d  = expected[{idx_q, 2'b00} +: 4];
  assign mismatch_d = (led_nib_d != exp_nib_d);
  assign last_d     = (cnt_q == LAST);

  // Sweep FSM: step through patterns, sample on the last dwell cycle, accumulate results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      cnt_q        <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_count_q <= 4'd0;
      fail_idx_q   <= 3'd0;
      resp_q       <= 32'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= DRIVE;
            idx_q        <= 3'd0;
            cnt_q        <= 8'd0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= 4'd0;
            fail_idx_q   <= 3'd0;
            resp_q       <= 32'd0;
          end
        end
        DRIVE: begin
          if (last_d) begin
            resp_q[{idx_q, 2'b00} +: 4] <= led_nib_d;
            if (mismatch_d) begin
              fail_count_q <= fail_count_q + 4'd1;
              if (fail_count_q == 4'd0) fail_idx_q <= idx_q;
            end
            cnt_q <= 8'd0;
            if (idx_q != 3'd7) begin
              idx_q <= idx_q + 3'd1;
            end else begin
              // sw stays on the final pattern while results are held
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (fail_count_q == 4'd0) && !mismatch_d;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pattern index maps MSB-first onto sw0..sw2
  assign sw0        = idx_q[2];
  assign sw1        = idx_q[1];
  assign sw2        = idx_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fail_count_q;
  assign fail_idx   = fail_idx_q;
  assign resp       = resp_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench for truth_table_sweeper (DWELL=4 and DWELL=1)
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [31:0] expected_a, expected_b;
  logic        force3;
  logic        led0_a, led1_a, led2_a, led3_a;
  logic        sw0_a, sw1_a, sw2_a, busy_a, done_a, pass_a;
  logic [3:0]  fail_count_a;
  logic [2:0]  fail_idx_a;
  logic [31:0] resp_a;
  logic        led0_b, led1_b, led2_b, led3_b;
  logic        sw0_b, sw1_b, sw2_b, busy_b, done_b, pass_b;
  logic [3:0]  fail_count_b;
  logic [2:0]  fail_idx_b;
  logic [31:0] resp_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0]  swq[$];
  logic [39:0] resq[$];

  always #5 clk = ~clk;

  // Logic under test: led0=sw2, led1=sw1, led2=sw0, led3=parity (optionally stuck at 0)
  assign led0_a = sw2_a;
  assign led1_a = sw1_a;
  assign led2_a = sw0_a;
  assign led3_a = force3 ? 1'b0 : (sw0_a ^ sw1_a ^ sw2_a);
  assign led0_b = sw2_b;
  assign led1_b = sw1_b;
  assign led2_b = sw0_b;
  assign led3_b = sw0_b ^ sw1_b ^ sw2_b;

  truth_table_sweeper #(.DWELL(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .expected(expected_a),
    .led0(led0_a), .led1(led1_a), .led2(led2_a), .led3(led3_a),
    .sw0(sw0_a), .sw1(sw1_a), .sw2(sw2_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_count(fail_count_a), .fail_idx(fail_idx_a), .resp(resp_a)
  );

  truth_table_sweeper #(.DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .expected(expected_b),
    .led0(led0_b), .led1(led1_b), .led2(led2_b), .led3(led3_b),
    .sw0(sw0_b), .sw1(sw1_b), .sw2(sw2_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_count(fail_count_b), .fail_idx(fail_idx_b), .resp(resp_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result {pass, fail_count, fail_idx, resp} for the LED model
  function automatic logic [39:0] model_result(input logic [31:0] exp, input logic f3);
    logic [31:0] r;
    logic [3:0]  cnt;
    logic [2:0]  first;
    logic [2:0]  q;
    logic [3:0]  nib;
    r = 32'd0; cnt = 4'd0; first = 3'd0;
    for (int p = 0; p < 8; p++) begin
      q   = 3'(p);
      nib = {(f3 ? 1'b0 : ^q), q};
      r[4*p +: 4] = nib;
      if (nib != exp[4*p +: 4]) begin
        if (cnt == 4'd0) first = q;
        cnt = cnt + 4'd1;
      end
    end
    return {(cnt == 4'd0), cnt, first, r};
  endfunction

  task automatic kick(input logic [31:0] exp, input bit hold);
    expected_a = exp;
    start_a    = 1'b1;
    tick();
    if (!hold) start_a = 1'b0;
  endtask

  // Called on the first DRIVE cycle; follows the sweep until busy drops and scores the result
  task automatic watch(input logic [31:0] exp, input logic f3, input int pulse_at);
    int          cyc;
    logic [2:0]  exp_sw;
    logic [39:0] r;
    for (int p = 0; p < 8; p++)
      for (int d = 0; d < 4; d++) swq.push_back(3'(p));
    resq.push_back(model_result(exp, f3));
    cyc = 0;
    while (busy_a === 1'b1 && cyc < 200) begin
      if (pulse_at >= 0 && cyc == pulse_at) start_a = 1'b1;
      else if (pulse_at >= 0 && cyc == pulse_at + 1) start_a = 1'b0;
      exp_sw = (swq.size() > 0) ? swq.pop_front() : 3'bxxx;
      chk("sw_seq", 32'({sw0_a, sw1_a, sw2_a}), 32'(exp_sw));
      cyc++;
      tick();
    end
    chk("busy_cycles", 32'(cyc), 32'd32);
    chk("sw_leftover", 32'(swq.size()), 32'd0);
    swq.delete();
    chk("done", 32'(done_a), 32'd1);
    chk("sw_hold", 32'({sw0_a, sw1_a, sw2_a}), 32'd7);
    r = (resq.size() > 0) ? resq.pop_front() : 40'hx;
    chk("pass", 32'(pass_a), 32'(r[39]));
    chk("fail_count", 32'(fail_count_a), 32'(r[38:35]));
    chk("fail_idx", 32'(fail_idx_a), 32'(r[34:32]));
    chk("resp", resp_a, r[31:0]);
  endtask

  task automatic chk_reset_a();
    chk("rst_sw", 32'({sw0_a, sw1_a, sw2_a}), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_fail_count", 32'(fail_count_a), 32'd0);
    chk("rst_fail_idx", 32'(fail_idx_a), 32'd0);
    chk("rst_resp", resp_a, 32'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; force3 = 1'b0;
    expected_a = 32'hF65C3A90; expected_b = 32'hF65C3A90;
    tick(); tick();
    rst = 1'b0;
    chk_reset_a();
    chk("rst_b_busy", 32'(busy_b), 32'd0);
    chk("rst_b_resp", resp_b, 32'd0);

    // All-pass sweep
    kick(32'hF65C3A90, 1'b0);
    watch(32'hF65C3A90, 1'b0, -1);

    // Nibble 5 wrong in the expected table
    kick(32'hF64C3A90, 1'b0);
    watch(32'hF64C3A90, 1'b0, -1);

    // led3 stuck low
    force3 = 1'b1;
    kick(32'hF65C3A90, 1'b0);
    watch(32'hF65C3A90, 1'b1, -1);
    force3 = 1'b0;

    // Reset while pattern 3 is on the switches
    kick(32'hF65C3A90, 1'b0);
    for (int i = 0; i < 12; i++) tick();
    chk("pre_rst_sw", 32'({sw0_a, sw1_a, sw2_a}), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_a();
    tick();
    chk("idle_busy", 32'(busy_a), 32'd0);
    kick(32'hF65C3A90, 1'b0);
    watch(32'hF65C3A90, 1'b0, -1);

    // start pulse mid-sweep must be ignored
    kick(32'hF65C3A90, 1'b0);
    watch(32'hF65C3A90, 1'b0, 10);

    // start held high: one done cycle then an immediate new sweep
    kick(32'hF64C3A90, 1'b1);
    watch(32'hF64C3A90, 1'b0, -1);
    tick();
    chk("b2b_done_low", 32'(done_a), 32'd0);
    chk("b2b_busy", 32'(busy_a), 32'd1);
    chk("b2b_resp_clr", resp_a, 32'd0);
    chk("b2b_fc_clr", 32'(fail_count_a), 32'd0);
    start_a = 1'b0;
    expected_a = 32'hF65C3A90;
    watch(32'hF65C3A90, 1'b0, -1);

    // DWELL=1 instance
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cyc = 0;
    while (busy_b === 1'b1 && cyc < 50) begin
      chk("b_sw_seq", 32'({sw0_b, sw1_b, sw2_b}), 32'(cyc % 8));
      cyc++;
      tick();
    end
    chk("b_busy_cycles", 32'(cyc), 32'd8);
    chk("b_done", 32'(done_b), 32'd1);
    chk("b_pass", 32'(pass_b), 32'd1);
    chk("b_fail_count", 32'(fail_count_b), 32'd0);
    chk("b_resp", resp_b, 32'hF65C3A90);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
